wdb_access_scheduler: RTL and testbench

Sequences all accesses to the single-port write data buffer (WDB) SRAM, which holds 1024-bit lines. Two requesters share it: write-data fills from the upstream data path, and buffer drains (reads) issued by the data-RAM write arbiter. Reads are queued and normally have priority. An entry-written bitmap holds back any read whose data has not yet landed. A bounded read streak keeps fills from starving. The block sits between the request arbiter / write-data channel and the WDB memory model, and produces the data stream toward SRAM write.

---
 rtl/wdb_access_scheduler.sv | 138 +++++++++++++
 tb/tb_wdb_access_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wdb_access_scheduler.sv
// Arbitrates the single-port WDB SRAM between queued drains and write-data fills.
// Define WDB_SCHED_STARVE_GUARD_EN to bound consecutive read grants while a fill waits.
module wdb_access_scheduler #(
    parameter int unsigned ENTRY_NUM     = 16,
    parameter int unsigned ID_W          = $clog2(ENTRY_NUM),
    parameter int unsigned DATA_W        = 1024,
    parameter int unsigned TAG_W         = 32,
    parameter int unsigned RQ_DEPTH      = 4,
    parameter int unsigned MAX_RD_STREAK = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rd_req_vld,
    input  logic [ID_W-1:0]           rd_req_id,
    input  logic [TAG_W-1:0]          rd_req_tag,
    output logic                      rd_req_rdy,
    input  logic                      wr_req_vld,
    input  logic [ID_W-1:0]           wr_req_id,
    input  logic [DATA_W-1:0]         wr_req_data,
    output logic                      wr_req_rdy,
    output logic                      mem_en,
    output logic                      mem_wr_en,
    output logic [ID_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]         mem_wr_data,
    input  logic [DATA_W-1:0]         mem_rd_data,
    output logic                      rd_rsp_vld,
    output logic [ID_W-1:0]           rd_rsp_id,
    output logic [TAG_W-1:0]          rd_rsp_tag,
    output logic [DATA_W-1:0]         rd_rsp_data,
    output logic [$clog2(RQ_DEPTH):0] rq_count,
    output logic                      err_overwrite
);

    localparam int unsigned PTR_W = $clog2(RQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ID_W-1:0]      q_id  [RQ_DEPTH];
    logic [TAG_W-1:0]     q_tag [RQ_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_nxt;
    logic [ENTRY_NUM-1:0] written;
    logic [ENTRY_NUM-1:0] written_nxt;
    logic [ID_W-1:0]      head_id;
    logic                 enq;
    logic                 rd_elig;
    logic                 force_wr;
    logic                 rd_issue;
    logic                 wr_issue;

    assign head_id  = q_id[rd_ptr];
    assign rd_elig  = (count != '0) && written[head_id];
    assign rd_issue = rd_elig && !force_wr;
    assign wr_req_rdy = !rd_issue;
    assign wr_issue = wr_req_vld && wr_req_rdy;
    assign enq      = rd_req_vld && rd_req_rdy;

    assign count_nxt = count + CNT_W'(enq) - CNT_W'(rd_issue);
    assign rq_count  = count;

    assign mem_en      = rd_issue || wr_issue;
    assign mem_wr_en   = wr_issue;
    assign mem_addr    = rd_issue ? head_id : wr_req_id;
    assign mem_wr_data = wr_req_data;
    assign rd_rsp_data = mem_rd_data;

`ifdef WDB_SCHED_STARVE_GUARD_EN
    localparam int unsigned STK_W = $clog2(MAX_RD_STREAK + 1);

    logic [STK_W-1:0] streak;

    assign force_wr = (streak == STK_W'(MAX_RD_STREAK));

    // Count reads granted while a fill is pending; any fill grant or idle fill side restarts it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (!wr_req_vld || wr_issue) begin
            streak <= '0;
        end else if (rd_issue && !force_wr) begin
            streak <= streak + STK_W'(1);
        end
    end
`else
    assign force_wr = 1'b0;
`endif

    // Clear on drain before set on fill; the two never coincide since grants are exclusive.
    always_comb begin
        written_nxt = written;
        if (rd_issue) begin
            written_nxt[head_id] = 1'b0;
        end
        if (wr_issue) begin
            written_nxt[wr_req_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            rd_req_rdy    <= 1'b0;
            written       <= '0;
            err_overwrite <= 1'b0;
            rd_rsp_vld    <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count      <= count_nxt;
            rd_req_rdy <= (count_nxt != CNT_W'(RQ_DEPTH));
            written    <= written_nxt;
            if (wr_issue && written[wr_req_id]) begin
                err_overwrite <= 1'b1;
            end
            rd_rsp_vld <= rd_issue;
        end
    end

    // Queue storage and response metadata need no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_id[wr_ptr]  <= rd_req_id;
            q_tag[wr_ptr] <= rd_req_tag;
        end
        if (rd_issue) begin
            rd_rsp_id  <= head_id;
            rd_rsp_tag <= q_tag[rd_ptr];
        end
    end

endmodule

// File: tb/tb_wdb_access_scheduler.sv
// Scoreboard bench for wdb_access_scheduler; responses checked against a queue of expected drains.
module tb_wdb_access_scheduler;

    localparam int unsigned ENTRY_NUM = 16;
    localparam int unsigned ID_W      = 4;
    localparam int unsigned DATA_W    = 1024;
    localparam int unsigned TAG_W     = 32;
    localparam int unsigned RQ_DEPTH  = 4;
    localparam int unsigned MAX_RD    = 8;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              rd_req_vld;
    logic [ID_W-1:0]   rd_req_id;
    logic [TAG_W-1:0]  rd_req_tag;
    logic              rd_req_rdy;
    logic              wr_req_vld;
    logic [ID_W-1:0]   wr_req_id;
    logic [DATA_W-1:0] wr_req_data;
    logic              wr_req_rdy;
    logic              mem_en;
    logic              mem_wr_en;
    logic [ID_W-1:0]   mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;
    logic              rd_rsp_vld;
    logic [ID_W-1:0]   rd_rsp_id;
    logic [TAG_W-1:0]  rd_rsp_tag;
    logic [DATA_W-1:0] rd_rsp_data;
    logic [2:0]        rq_count;
    logic              err_overwrite;

    logic [DATA_W-1:0] sram   [ENTRY_NUM];
    logic [DATA_W-1:0] shadow [ENTRY_NUM];
    exp_t              exp_q[$];
    int                checks;
    int                errors;
    int                n_push;
    int                n_rsp;

    wdb_access_scheduler #(
        .ENTRY_NUM(ENTRY_NUM), .ID_W(ID_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
        .RQ_DEPTH(RQ_DEPTH), .MAX_RD_STREAK(MAX_RD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req_vld(rd_req_vld), .rd_req_id(rd_req_id), .rd_req_tag(rd_req_tag),
        .rd_req_rdy(rd_req_rdy),
        .wr_req_vld(wr_req_vld), .wr_req_id(wr_req_id), .wr_req_data(wr_req_data),
        .wr_req_rdy(wr_req_rdy),
        .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .rd_rsp_vld(rd_rsp_vld), .rd_rsp_id(rd_rsp_id), .rd_rsp_tag(rd_rsp_tag),
        .rd_rsp_data(rd_rsp_data), .rq_count(rq_count), .err_overwrite(err_overwrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port SRAM model with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wr_en) sram[mem_addr] <= mem_wr_data;
            else           mem_rd_data    <= sram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk_data(input int id, input int salt);
        logic [31:0] w;
        w = {16'(salt), 8'(id), 8'h5A};
        return {32{w}};
    endfunction

    // Response checker: pops the oldest expected drain; data comes from the fill shadow.
    always @(negedge clk) begin
        if (rd_rsp_vld === 1'b1) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 256'(rd_rsp_vld), 256'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_id", 256'(rd_rsp_id), 256'(e.id));
                chk("rsp_tag", 256'(rd_rsp_tag), 256'(e.tag));
                for (int c = 0; c < 4; c++) begin
                    chk($sformatf("rsp_data%0d", c), rd_rsp_data[c*256 +: 256],
                        shadow[e.id][c*256 +: 256]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int id, input logic [DATA_W-1:0] data);
        wr_req_vld  = 1'b1;
        wr_req_id   = ID_W'(id);
        wr_req_data = data;
        @(negedge clk);
        chk("fill_rdy", 256'(wr_req_rdy), 256'(1));
        chk("fill_en", 256'({mem_en, mem_wr_en}), 256'(2'b11));
        chk("fill_addr", 256'(mem_addr), 256'(id));
        shadow[id] = data;
        step();
        wr_req_vld = 1'b0;
    endtask

    task automatic send_rd(input int id, input int tag, input bit push);
        rd_req_vld = 1'b1;
        rd_req_id  = ID_W'(id);
        rd_req_tag = TAG_W'(tag);
        @(negedge clk);
        chk("rd_rdy", 256'(rd_req_rdy), 256'(1));
        if (push) begin
            exp_q.push_back('{id: ID_W'(id), tag: TAG_W'(tag)});
            n_push++;
        end
        step();
        rd_req_vld = 1'b0;
    endtask

    task automatic expect_read(input int id);
        @(negedge clk);
        chk("rd_strobe", 256'({mem_en, mem_wr_en}), 256'(2'b10));
        chk("rd_addr", 256'(mem_addr), 256'(id));
        step();
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        chk(tag, 256'(mem_en), 256'(0));
        step();
    endtask

    initial begin
        checks = 0; errors = 0; n_push = 0; n_rsp = 0;
        rst_n = 1'b0;
        rd_req_vld = 1'b0; rd_req_id = '0; rd_req_tag = '0;
        wr_req_vld = 1'b0; wr_req_id = '0; wr_req_data = '0;
        for (int i = 0; i < int'(ENTRY_NUM); i++) shadow[i] = '0;

        // Reset values
        repeat (3) step();
        @(negedge clk);
        chk("rst_rd_rdy", 256'(rd_req_rdy), 256'(0));
        chk("rst_wr_rdy", 256'(wr_req_rdy), 256'(1));
        chk("rst_mem_en", 256'(mem_en), 256'(0));
        chk("rst_count", 256'(rq_count), 256'(0));
        chk("rst_rsp_vld", 256'(rd_rsp_vld), 256'(0));
        chk("rst_err", 256'(err_overwrite), 256'(0));
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("rel_rd_rdy", 256'(rd_req_rdy), 256'(1));
        step();

        // Fill then drain id 3; response two cycles after acceptance
        fill(3, {128{8'hA5}});
        send_rd(3, 32'h11, 1'b1);
        expect_read(3);
        @(negedge clk);
        chk("rsp_latency", 256'(rd_rsp_vld), 256'(1));
        step();
        // written[3] was cleared by the drain, so a second read must wait for a refill
        send_rd(3, 32'h33, 1'b1);
        expect_idle("wait3_a");
        expect_idle("wait3_b");
        fill(3, mk_data(3, 1));
        expect_read(3);
        chk("no_err_after_drain", 256'(err_overwrite), 256'(0));

        // Read to unwritten entry holds until filled
        send_rd(5, 32'h22, 1'b1);
        repeat (3) expect_idle("wait5");
        chk("hold_count", 256'(rq_count), 256'(1));
        fill(5, mk_data(5, 2));
        expect_read(5);
        step();

        // Queue full
        for (int i = 8; i < 12; i++) send_rd(i, 32'h80 + i - 8, 1'b1);
        rd_req_vld = 1'b1; rd_req_id = 4'd12; rd_req_tag = 32'h84;
        @(negedge clk);
        chk("full_count", 256'(rq_count), 256'(4));
        chk("full_rdy", 256'(rd_req_rdy), 256'(0));
        chk("full_idle", 256'(mem_en), 256'(0));
        step();
        rd_req_vld = 1'b0;
        chk("full_no_accept", 256'(rq_count), 256'(4));
        fill(8, mk_data(8, 3));
        @(negedge clk);
        chk("pop_at_full_rdy", 256'(rd_req_rdy), 256'(0));
        chk("pop_strobe", 256'({mem_en, mem_wr_en}), 256'(2'b10));
        chk("pop_addr", 256'(mem_addr), 256'(8));
        step();
        chk("after_pop_rdy", 256'(rd_req_rdy), 256'(1));
        chk("after_pop_count", 256'(rq_count), 256'(3));
        for (int i = 9; i < 12; i++) begin
            fill(i, mk_data(i, 4));
            expect_read(i);
        end
        step();

        // Overwrite error is sticky
        fill(7, mk_data(7, 5));
        chk("err_first_fill", 256'(err_overwrite), 256'(0));
        fill(7, mk_data(7, 6));
        chk("err_set", 256'(err_overwrite), 256'(1));
        send_rd(7, 32'h77, 1'b1);
        expect_read(7);
        repeat (3) step();
        chk("err_sticky", 256'(err_overwrite), 256'(1));

        // Preload, then continuous reads against a continuously requesting fill
        for (int i = 0; i < int'(ENTRY_NUM); i++) fill(i, mk_data(i, 7));
        wr_req_vld  = 1'b1;
        wr_req_id   = 4'd15;
        wr_req_data = shadow[15];
        for (int k = 0; k < 18; k++) begin
            bit exp_w;
`ifdef WDB_SCHED_STARVE_GUARD_EN
            exp_w = (k == 0) || (k == 9) || (k >= 17);
`else
            exp_w = (k == 0) || (k >= 16);
`endif
            if (k < 15) begin
                rd_req_vld = 1'b1;
                rd_req_id  = ID_W'(k);
                rd_req_tag = TAG_W'(32'h100 + k);
                exp_q.push_back('{id: ID_W'(k), tag: TAG_W'(32'h100 + k)});
                n_push++;
            end else begin
                rd_req_vld = 1'b0;
            end
            @(negedge clk);
            if (k < 15) chk($sformatf("strm_rd_rdy%0d", k), 256'(rd_req_rdy), 256'(1));
            chk($sformatf("strm_wr_rdy%0d", k), 256'(wr_req_rdy), 256'(exp_w));
            chk($sformatf("strm_acc%0d", k), 256'({mem_en, mem_wr_en}), 256'({1'b1, exp_w}));
            step();
        end
        wr_req_vld = 1'b0;
        rd_req_vld = 1'b0;
        step();

        // Reset during an issued read drops the response and empties the queue
        send_rd(15, 32'h99, 1'b0);
        rd_req_vld = 1'b1; rd_req_id = 4'd2; rd_req_tag = 32'h98;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_strobe", 256'({mem_en, mem_wr_en}), 256'(2'b10));
        chk("mid_rst_addr", 256'(mem_addr), 256'(15));
        step();
        rd_req_vld = 1'b0;
        @(negedge clk);
        chk("mid_rst_rsp_vld", 256'(rd_rsp_vld), 256'(0));
        chk("mid_rst_count", 256'(rq_count), 256'(0));
        chk("mid_rst_rd_rdy", 256'(rd_req_rdy), 256'(0));
        chk("mid_rst_err", 256'(err_overwrite), 256'(0));
        chk("mid_rst_wr_rdy", 256'(wr_req_rdy), 256'(1));
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("rel2_rd_rdy", 256'(rd_req_rdy), 256'(1));
        step();
        // written bitmap was cleared by reset
        send_rd(15, 32'h9A, 1'b1);
        expect_idle("post_rst_wait");
        fill(15, mk_data(15, 8));
        expect_read(15);
        repeat (3) step();

        chk("sb_empty", 256'(exp_q.size()), 256'(0));
        chk("rsp_total", 256'(n_rsp), 256'(n_push));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
